alu_issue_unit: RTL
===================

Name: alu_issue_unit

Overview:
- Sequential initiator that drives the 32-bit combinational ALU: it accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal register file.
- It presents operands and the opcode to the ALU, captures the ALU result, writes it back, and returns result plus status flags over a second valid/ready handshake.
- It sits between the instruction/test source and the ALU, and is the single owner of the ALU's a/b/alu_op inputs.

Parameters:
DATA_W, 32, operand/result width; must match the ALU (32)
REG_AW, 3, register address width; register file has 2**REG_AW entries

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  unit can accept an instruction
in_op  input  3  operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110/111 reserved (ALU returns 0)
in_rd  input  REG_AW  destination register
in_rs  input  REG_AW  source register for operand a
in_rt  input  REG_AW  source register for operand b
ld_en  input  1  direct register load strobe
ld_addr  input  REG_AW  load address
ld_data  input  DATA_W  load data
alu_a  output  DATA_W  to ALU a
alu_b  output  DATA_W  to ALU b
alu_op  output  4  to ALU alu_op; bit 3 always 0
alu_result  input  DATA_W  from ALU result
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  DATA_W  captured result
out_rd  output  REG_AW  destination of result
out_zero  output  1  out_result == 0
out_ovf  output  1  signed overflow; add/sub only, else 0

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - All register-file entries, alu_a, alu_b, alu_op, out_result, out_rd, out_zero, out_ovf and out_valid are cleared to 0.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-operation abandons the instruction with no writeback.
- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready = 1. A handshake (in_valid & in_ready) at edge T latches alu_a = reg[in_rs], alu_b = reg[in_rt], alu_op = {1'b0, in_op} and rd, then moves to EXEC.
  - EXEC: in_ready = 0. ALU inputs are stable for the full cycle. At edge T+1 the unit:
    - captures alu_result into out_result;
    - computes out_zero;
    - computes out_ovf from alu_a/alu_b signs and result sign: add → same operand signs and result sign differs; sub → operand signs differ and result sign differs from a;
    - writes reg[rd] = alu_result;
    - sets out_valid = 1 and moves to WB.
  - WB: in_ready = 0. out_* are held stable while out_valid & !out_ready. On out_valid & out_ready at an edge, out_valid drops to 0 and the FSM returns to IDLE. The next instruction can be accepted the cycle after the return.
- Latency and throughput: instruction accept → out_valid is 2 cycles. Minimum issue interval is 3 cycles.
- Operands are read at accept time. Since only one instruction is in flight, back-to-back dependent instructions see the written-back value.
- rs == rt is legal; both operands receive the same value.
- ALU inputs hold their last values in IDLE and WB; they are not zeroed.
- Load port:
  - ld_en writes reg[ld_addr] = ld_data at the edge, in any state.
  - If ld_en targets rd in the same edge as the EXEC writeback, the writeback wins and the load is dropped.
  - A load to a source register in the same edge as the instruction accept does not affect the latched operands; the pre-edge value is used.
- Arithmetic wraps modulo 2**DATA_W. Flags are never sticky; they are recomputed per instruction.

Optional Feature:
- Macro: ALU_ISSUE_CHECK_EN.
- When defined:
  - The unit internally computes the expected result from alu_a/alu_b/alu_op (same encoding; reserved → 0) in EXEC.
  - It adds output port chk_err (1 bit, reset 0). chk_err is set sticky at the EXEC edge if alu_result differs from the expected value, and is cleared only by reset.
- When undefined: no port and no checker logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release → in_ready=1, out_valid=0, all outputs 0.
- Add: load r1=5, r2=7; issue add rd=3 rs=1 rt=2 → out_valid exactly 2 cycles after accept, out_result=12, out_rd=3, zero=0, ovf=0; reg3=12 confirmed via follow-up or r3,r0 → 12.
- Overflow: r1=0x7FFFFFFF, r2=1, add → result 0x80000000, ovf=1. Also r4=0x80000000, r2=1, sub rd=5 rs=4 rt=2 → 0x7FFFFFFF, ovf=1.
- Zero and reserved op: xor r1,r1 → result 0, zero=1. Op 110 → result 0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles → out_* stable, in_ready=0, in_valid ignored. Then out_ready=1 → one transfer, IDLE next cycle.
- Collision and reset: ld_en to rd on the EXEC edge → writeback value retained. rst_n=0 during EXEC → no out_valid, all registers 0. With ALU_ISSUE_CHECK_EN, force alu_result=0xDEAD for an add of 1+1 → chk_err=1 and stays 1.

Source files
------------

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue FSM that owns the external 32-bit ALU and its register file
//
// Optional checker: define ALU_ISSUE_CHECK_EN to add the chk_err port and an
// internal result cross-check performed in EXEC.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               instruction handshake
//   in_op, in_rd, in_rs, in_rt      opcode, destination, source registers
//   ld_en, ld_addr, ld_data         direct register-file load (any state)
//   alu_a, alu_b, alu_op            operands/opcode presented to the ALU
//   alu_result                      combinational result from the ALU
//   out_valid/out_ready             result handshake
//   out_result, out_rd              captured result and its destination
//   out_zero, out_ovf               result flags (ovf for add/sub only)
//   chk_err                         sticky ALU mismatch (ALU_ISSUE_CHECK_EN only)

module alu_issue_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_zero,
  output logic              out_ovf
`ifdef ALU_ISSUE_CHECK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int NREG = 1 << REG_AW;
  localparam int MSB  = DATA_W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [REG_AW-1:0] r_rd;
  logic              w_accept;
  logic              w_zero;
  logic              w_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // out_valid is always set on entry to WB, so out_ready alone ends the transfer.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_WB;
      S_WB: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_zero   = (alu_result == '0);

  // Signed overflow from sign bits only: add overflows when like-signed
  // operands give a differently signed result; sub when unlike-signed
  // operands give a result whose sign differs from a.
  always_comb begin
    w_ovf = 1'b0;
    case (alu_op)
      4'd0: w_ovf = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      4'd1: w_ovf = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      r_rd       <= '0;
      out_result <= '0;
      out_rd     <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      // The load is scheduled first so that a same-edge EXEC writeback to
      // the same register overrides it.
      if (ld_en) begin
        r_regs[ld_addr] <= ld_data;
      end
      case (r_state)
        S_IDLE: begin
          // Register reads here see the pre-edge contents, so a same-edge
          // load to a source register does not leak into the operands.
          if (w_accept) begin
            alu_a  <= r_regs[in_rs];
            alu_b  <= r_regs[in_rt];
            alu_op <= {1'b0, in_op};
            r_rd   <= in_rd;
          end
        end
        S_EXEC: begin
          out_result   <= alu_result;
          out_rd       <= r_rd;
          out_zero     <= w_zero;
          out_ovf      <= w_ovf;
          r_regs[r_rd] <= alu_result;
          out_valid    <= 1'b1;
        end
        S_WB: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  logic [DATA_W-1:0] w_expected;

  always_comb begin
    w_expected = '0;
    case (alu_op)
      4'd0: w_expected = alu_a + alu_b;
      4'd1: w_expected = alu_a - alu_b;
      4'd2: w_expected = alu_a & alu_b;
      4'd3: w_expected = alu_a | alu_b;
      4'd4: w_expected = alu_a ^ alu_b;
      4'd5: w_expected = ~(alu_a | alu_b);
      default: w_expected = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if ((r_state == S_EXEC) && (alu_result != w_expected)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule
